demux_channel_sequencer: RTL
============================

Name: demux_channel_sequencer

Overview:
- Upstream driver for the 1-to-8 demultiplexer stage: produces its `in` bit and 3-bit `select_lines`.
- On a start handshake, latches an 8-bit channel mask and a route bit.
- Walks the enabled channels lowest-to-highest, holding each channel selected for a fixed dwell time.
- Pulses `done` when the walk finishes; outputs connect directly to the demux `in`/`select_lines` inputs.

Parameters:
- DWELL_CYCLES, 20: clock cycles each enabled channel stays selected. A value of 0 is treated as 1.
- DWELL_W, 8: width of the dwell counter. Requires DWELL_CYCLES <= 2**DWELL_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_valid  input  1  request to begin a sequence.
- start_ready  output  1  high only in IDLE; a request is accepted when start_valid && start_ready at a rising edge.
- channel_mask  input  8  channels to visit; sampled on accept.
- data_in  input  1  bit to route; sampled on accept.
- in  output  1  demux data input; the latched route bit during dwell, 0 otherwise.
- select_lines  output  3  demux select; the current channel index.
- busy  output  1  high from the cycle after accept through the DONE cycle inclusive.
- done  output  1  one-cycle pulse at sequence end.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - in=0, select_lines=3'b000, busy=0, done=0, start_ready=1.
  - Latched mask and route bit cleared; dwell counter = 0.
- States: IDLE, DWELL, DONE (plus GUARD when the optional feature is enabled). All outputs are registered.
- IDLE:
  - start_ready=1, in=0, select_lines=0.
  - On accept with mask != 0, the next cycle is DWELL with:
    - select_lines = index of the lowest set mask bit;
    - in = data_in;
    - counter = 0;
    - busy = 1.
  - On accept with mask == 0, the next cycle is DONE with busy=1, done=1, in=0; no channel is driven.
  - start_valid is ignored outside IDLE: no queuing and no effect on the running sequence.
- DWELL:
  - Counter increments every cycle.
  - After exactly DWELL_CYCLES cycles in the current channel:
    - If the latched mask has a set bit above the current index, move to the lowest such index. The next channel is selected on the very next cycle with no gap, and in stays equal to the route bit.
    - Otherwise go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, in=0, select_lines=0.
  - Then IDLE; start_ready=1 from the following cycle.
- Latency: accept edge to first channel driven = 1 cycle. Total busy cycles = popcount(mask) * max(DWELL_CYCLES,1) + 1.
- Channel index arithmetic is 3-bit, with no wrap: a walk never returns below its start index. Channel 7 is always the last visited if set.
- The route bit is held constant for the whole sequence, even if data_in changes after accept.
- Reset asserted mid-sequence aborts immediately to the reset values; no done pulse is generated.
- in and select_lines change together on the same edge; select_lines never changes while in is 0 except on entry to IDLE or DONE.

Optional Feature:
- Macro: DEMUX_SEQ_GUARD_EN.
- Defined:
  - Between consecutive channels, insert one GUARD cycle with in=0 and select_lines holding the previous channel. The new channel and in=route bit appear on the following cycle (break-before-make).
  - Busy cycles increase by popcount(mask)-1 when popcount(mask) >= 2.
  - No guard cycle before the first channel or before DONE.
- Undefined: the GUARD state does not exist; channel transitions are back-to-back as described above.

Test Plan (DWELL_CYCLES=4 unless stated):
- Reset, then mask=8'b0000_0101, data_in=1 -> 4 cycles with select=0,in=1; then 4 cycles with select=2,in=1; then 1 cycle with done=1,in=0; busy high for 9 cycles; start_ready returns in cycle 10.
- mask=8'hFF, data_in=1 -> select steps 0..7, 4 cycles each, 32 contiguous cycles with in=1, then done; with DEMUX_SEQ_GUARD_EN: 7 guard cycles with in=0, busy=40 cycles.
- mask=8'h00 -> done=1 in the cycle after accept, in never 1, busy=1 for exactly 1 cycle.
- mask=8'h80, data_in=0 -> select=7 for 4 cycles with in=0; data_in toggled to 1 during dwell -> in stays 0.
- Assert start_valid continuously with mask=8'h03 -> exactly one accept per sequence; the second accept occurs only in IDLE after done; no overlap.
- mask=8'h10, reset asserted on the 2nd dwell cycle -> in=0, select=0, busy=0 immediately (asynchronous), no done pulse; a new start is accepted once reset is released.

Source files
------------

// File: rtl/demux_channel_sequencer.sv
// demux_channel_sequencer: walks the enabled channels of a latched mask, driving the demux in/select_lines.
// Define DEMUX_SEQ_GUARD_EN to insert a break-before-make guard cycle between channels.
module demux_channel_sequencer #(
  parameter int DWELL_CYCLES = 20,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [7:0] channel_mask,
  input  logic       data_in,
  output logic       in,
  output logic [2:0] select_lines,
  output logic       busy,
  output logic       done
);
  localparam int DW = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DW - 1);
  typedef enum logic [1:0] {IDLE, DWELL, DONE, GUARD} state_t;
  state_t state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic route_q, route_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic in_q, in_d, busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic [7:0] above;
  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  // channels strictly above the current one; shifting out of 8 bits makes channel 7 terminal
  assign above = mask_q & (8'hFE << sel_q);
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    route_d = route_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    in_d = in_q;
    busy_d = busy_q;
    done_d = done_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: if (start_valid) begin
        mask_d = channel_mask;
        route_d = data_in;
        busy_d = 1'b1;
        ready_d = 1'b0;
        cnt_d = '0;
        if (|channel_mask) begin
          state_d = DWELL;
          sel_d = lowest(channel_mask);
          in_d = data_in;
        end else begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      DWELL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (|above) begin
`ifdef DEMUX_SEQ_GUARD_EN
            state_d = GUARD;
            in_d = 1'b0;
`else
            sel_d = lowest(above);
            in_d = route_q;
`endif
          end else begin
            state_d = DONE;
            done_d = 1'b1;
            in_d = 1'b0;
            sel_d = 3'd0;
          end
        end
      end
      GUARD: begin
        state_d = DWELL;
        sel_d = lowest(above);
        in_d = route_q;
      end
      default: begin
        state_d = IDLE;
        done_d = 1'b0;
        busy_d = 1'b0;
        ready_d = 1'b1;
        in_d = 1'b0;
        sel_d = 3'd0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q <= '0;
      route_q <= 1'b0;
      cnt_q <= '0;
      sel_q <= 3'd0;
      in_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      route_q <= route_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      in_q <= in_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ready_q <= ready_d;
    end
  end
  assign start_ready = ready_q;
  assign in = in_q;
  assign select_lines = sel_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
